// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the I/D memory port arbiter.
//   state_t : arbiter FSM states (IDLE, REQ, RESP)
//   OWN_I   : owner encoding for the instruction channel (also grant bit 0)
//   OWN_D   : owner encoding for the data channel (also grant bit 1)
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin arbiter. On contention the requester that did NOT win
// last time is granted; a lone requester is always granted.
//   i_req[1:0]    : request vector, bit 0 = I channel, bit 1 = D channel
//   i_last_grant  : owner granted most recently (OWN_I / OWN_D)
//   o_grant[1:0]  : one-hot grant (all zero when nobody requests)
// ---------------------------------------------------------------------------
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic [1:0] o_grant
);

  // Grant selection; contention resolved against the previous winner
  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = (i_last_grant == OWN_D) ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares a single memory-controller port between the CPU instruction (I) and
// data (D) channels. One transaction outstanding at a time, round-robin on
// contention, writes complete when the controller accepts them.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_req_* / i_resp_*         instruction fetch request / response channel
//   d_rd, d_wr, d_addr, d_wdata, d_wstrb, d_req_ready   data request channel
//   d_resp_*                   data read response channel
//   bus_req_*, bus_addr, bus_wen, bus_wdata, bus_wstrb  controller request
//   bus_resp_*                 controller read response
//   cnt_i_grant, cnt_d_grant   grant counters per channel
//   cnt_conflict               IDLE cycles with both channels requesting
//   cnt_stall                  cycles spent in REQ or RESP
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req_valid,
  input  logic [ADDR_W-1:0]     i_req_addr,
  output logic                  i_req_ready,
  output logic                  i_resp_valid,
  output logic [DATA_W-1:0]     i_resp_data,
  input  logic                  i_resp_ready,
  input  logic                  d_rd,
  input  logic                  d_wr,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_wstrb,
  output logic                  d_req_ready,
  output logic                  d_resp_valid,
  output logic [DATA_W-1:0]     d_resp_data,
  input  logic                  d_resp_ready,
  output logic                  bus_req_valid,
  input  logic                  bus_req_ready,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic                  bus_wen,
  output logic [DATA_W-1:0]     bus_wdata,
  output logic [DATA_W/8-1:0]   bus_wstrb,
  input  logic                  bus_resp_valid,
  input  logic [DATA_W-1:0]     bus_resp_data,
  output logic                  bus_resp_ready,
  output logic [CNT_W-1:0]      cnt_i_grant,
  output logic [CNT_W-1:0]      cnt_d_grant,
  output logic [CNT_W-1:0]      cnt_conflict,
  output logic [CNT_W-1:0]      cnt_stall
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t              r_state;
  logic                r_owner;
  logic                r_last_grant;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wen;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_wstrb;
  logic [CNT_W-1:0]    r_cnt_i_grant;
  logic [CNT_W-1:0]    r_cnt_d_grant;
  logic [CNT_W-1:0]    r_cnt_conflict;
  logic [CNT_W-1:0]    r_cnt_stall;

  logic                w_idle;
  logic                w_d_req;
  logic [1:0]          w_req;
  logic [1:0]          w_grant;
  logic [1:0]          w_take;

  assign w_idle  = (r_state == ST_IDLE);
  assign w_d_req = d_rd | d_wr;
  assign w_req   = {w_d_req, i_req_valid};

  rr_arbiter2 u_rr_arbiter2 (
    .i_req        (w_req),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  // Grants only take effect while IDLE, so a new request can never be
  // accepted in the same cycle the previous one leaves the arbiter.
  assign w_take = w_idle ? w_grant : 2'b00;

  assign i_req_ready   = w_take[0];
  assign d_req_ready   = w_take[1];
  assign bus_req_valid = (r_state == ST_REQ);
  assign bus_addr      = r_addr;
  assign bus_wen       = r_wen;
  assign bus_wdata     = r_wdata;
  assign bus_wstrb     = r_wstrb;
  assign cnt_i_grant   = r_cnt_i_grant;
  assign cnt_d_grant   = r_cnt_d_grant;
  assign cnt_conflict  = r_cnt_conflict;
  assign cnt_stall     = r_cnt_stall;

  // Response steering: only the owner sees the read data handshake
  always_comb begin
    bus_resp_ready = 1'b0;
    i_resp_valid   = 1'b0;
    d_resp_valid   = 1'b0;
    i_resp_data    = {DATA_W{1'b0}};
    d_resp_data    = {DATA_W{1'b0}};
    case (r_state)
      // IDLE accepts and discards stray responses left over from an
      // abandoned transaction.
      ST_IDLE: bus_resp_ready = 1'b1;
      ST_REQ:  bus_resp_ready = 1'b0;
      ST_RESP: begin
        i_resp_data = bus_resp_data;
        d_resp_data = bus_resp_data;
        if (r_owner == OWN_D) begin
          bus_resp_ready = d_resp_ready;
          d_resp_valid   = bus_resp_valid;
        end else begin
          bus_resp_ready = i_resp_ready;
          i_resp_valid   = bus_resp_valid;
        end
      end
      default: bus_resp_ready = 1'b1;
    endcase
  end

  // FSM, grant bookkeeping and request payload capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_owner      <= OWN_I;
      r_last_grant <= OWN_D;
      r_addr       <= {ADDR_W{1'b0}};
      r_wen        <= 1'b0;
      r_wdata      <= {DATA_W{1'b0}};
      r_wstrb      <= {STRB_W{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_take[1]) begin
            // A simultaneous read and write is treated as a write.
            r_owner      <= OWN_D;
            r_last_grant <= OWN_D;
            r_addr       <= d_addr;
            r_wen        <= d_wr;
            r_wdata      <= d_wr ? d_wdata : {DATA_W{1'b0}};
            r_wstrb      <= d_wr ? d_wstrb : {STRB_W{1'b0}};
            r_state      <= ST_REQ;
          end else if (w_take[0]) begin
            r_owner      <= OWN_I;
            r_last_grant <= OWN_I;
            r_addr       <= i_req_addr;
            r_wen        <= 1'b0;
            r_wdata      <= {DATA_W{1'b0}};
            r_wstrb      <= {STRB_W{1'b0}};
            r_state      <= ST_REQ;
          end else begin
            r_state      <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (bus_req_ready) begin
            // Writes are complete on acceptance; reads wait for data.
            r_state <= r_wen ? ST_IDLE : ST_RESP;
          end else begin
            r_state <= ST_REQ;
          end
        end
        ST_RESP: begin
          if (bus_resp_valid && bus_resp_ready) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_RESP;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Performance counters; wrap silently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_i_grant  <= {CNT_W{1'b0}};
      r_cnt_d_grant  <= {CNT_W{1'b0}};
      r_cnt_conflict <= {CNT_W{1'b0}};
      r_cnt_stall    <= {CNT_W{1'b0}};
    end else begin
      if (w_take[0]) begin
        r_cnt_i_grant <= r_cnt_i_grant + CNT_ONE;
      end else begin
        r_cnt_i_grant <= r_cnt_i_grant;
      end
      if (w_take[1]) begin
        r_cnt_d_grant <= r_cnt_d_grant + CNT_ONE;
      end else begin
        r_cnt_d_grant <= r_cnt_d_grant;
      end
      if (w_idle && i_req_valid && w_d_req) begin
        r_cnt_conflict <= r_cnt_conflict + CNT_ONE;
      end else begin
        r_cnt_conflict <= r_cnt_conflict;
      end
      if (!w_idle) begin
        r_cnt_stall <= r_cnt_stall + CNT_ONE;
      end else begin
        r_cnt_stall <= r_cnt_stall;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter: directed scenarios followed by a
// randomized phase, checked against a transaction-level reference model that
// tracks the expected winner, payload and counter totals.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req_valid;
  logic [31:0] i_req_addr;
  logic        i_req_ready;
  logic        i_resp_valid;
  logic [31:0] i_resp_data;
  logic        i_resp_ready;
  logic        d_rd;
  logic        d_wr;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_req_ready;
  logic        d_resp_valid;
  logic [31:0] d_resp_data;
  logic        d_resp_ready;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [31:0] bus_addr;
  logic        bus_wen;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_resp_valid;
  logic [31:0] bus_resp_data;
  logic        bus_resp_ready;
  logic [31:0] cnt_i_grant;
  logic [31:0] cnt_d_grant;
  logic [31:0] cnt_conflict;
  logic [31:0] cnt_stall;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
    .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data), .i_resp_ready(i_resp_ready),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_req_ready(d_req_ready), .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
    .d_resp_ready(d_resp_ready),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_addr(bus_addr),
    .bus_wen(bus_wen), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_resp_valid(bus_resp_valid), .bus_resp_data(bus_resp_data),
    .bus_resp_ready(bus_resp_ready),
    .cnt_i_grant(cnt_i_grant), .cnt_d_grant(cnt_d_grant),
    .cnt_conflict(cnt_conflict), .cnt_stall(cnt_stall)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: who won last, expected counter totals, expected payload
  bit          m_last_d;
  int unsigned m_i_grant, m_d_grant, m_conflict, m_stall;
  bit          m_own_d, m_wen;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last_d   = 1'b1;
    m_i_grant  = 0;
    m_d_grant  = 0;
    m_conflict = 0;
    m_stall    = 0;
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_cnt_i_grant"},  cnt_i_grant,  m_i_grant);
    chk({tag, "_cnt_d_grant"},  cnt_d_grant,  m_d_grant);
    chk({tag, "_cnt_conflict"}, cnt_conflict, m_conflict);
    chk({tag, "_cnt_stall"},    cnt_stall,    m_stall);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_req_valid = 1'b0; i_req_addr = 32'h0; i_resp_ready = 1'b1;
    d_rd = 1'b0; d_wr = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_wstrb = 4'h0;
    d_resp_ready = 1'b1; bus_req_ready = 1'b0; bus_resp_valid = 1'b0;
    bus_resp_data = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready_pair", {i_req_ready, d_req_ready}, 2'b00);
    chk("rst_resp_valid_pair", {i_resp_valid, d_resp_valid}, 2'b00);
    chk("rst_bus_req_valid", bus_req_valid, 1'b0);
    chk("rst_bus_resp_ready", bus_resp_ready, 1'b1);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_wen", bus_wen, 1'b0);
    chk("rst_bus_wdata", bus_wdata, 32'h0);
    chk("rst_bus_wstrb", bus_wstrb, 4'h0);
    model_reset();
    chk_cnt("rst");
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // One IDLE cycle with the given requests; the model predicts the winner.
  task automatic grant(input bit iv, input logic [31:0] ia, input bit drd, input bit dwr,
                       input logic [31:0] da, input logic [31:0] dw, input logic [3:0] ds,
                       input bit hold, output bit won_d);
    bit          dreq;
    logic [31:0] scr;
    i_req_valid = iv; i_req_addr = ia;
    d_rd = drd; d_wr = dwr; d_addr = da; d_wdata = dw; d_wstrb = ds;
    dreq = drd | dwr;
    if (iv && dreq) begin
      m_conflict++;
      won_d = !m_last_d;
    end else begin
      won_d = dreq;
    end
    m_last_d = won_d;
    if (won_d) m_d_grant++; else m_i_grant++;
    m_own_d = won_d;
    m_wen   = won_d && dwr;
    m_addr  = won_d ? da : ia;
    m_wdata = dw;
    m_wstrb = m_wen ? ds : 4'h0;
    @(negedge clk);
    chk("idle_bus_req_valid", bus_req_valid, 1'b0);
    chk("idle_bus_resp_ready", bus_resp_ready, 1'b1);
    chk("grant_i_req_ready", i_req_ready, !won_d);
    chk("grant_d_req_ready", d_req_ready, won_d);
    @(posedge clk); #1;
    if (!hold) begin
      i_req_valid = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
    end
    // Scramble request inputs so the REQ checks prove the payload was latched
    scr = $urandom; i_req_addr = scr;
    scr = $urandom; d_addr = scr;
    scr = $urandom; d_wdata = scr; d_wstrb = scr[3:0];
  endtask

  // Controller side of the granted transaction.
  task automatic serve(input int req_wait, input int resp_wait, input int rr_low,
                       input logic [31:0] rdata);
    bit          v, own_rdy;
    logic [31:0] scr;
    for (int k = 0; k <= req_wait; k++) begin
      bus_req_ready = (k == req_wait);
      @(negedge clk);
      chk("req_bus_req_valid", bus_req_valid, 1'b1);
      chk("req_bus_addr", bus_addr, m_addr);
      chk("req_bus_wen", bus_wen, m_wen);
      chk("req_bus_wstrb", bus_wstrb, m_wstrb);
      if (m_wen) chk("req_bus_wdata", bus_wdata, m_wdata);
      chk("req_no_new_grant", {i_req_ready, d_req_ready}, 2'b00);
      @(posedge clk); #1;
      m_stall++;
    end
    bus_req_ready = 1'b0;
    if (!m_wen) begin
      for (int k = 0; k <= resp_wait + rr_low; k++) begin
        v       = (k >= resp_wait);
        own_rdy = (k < resp_wait) || (k == resp_wait + rr_low);
        scr     = $urandom;
        bus_resp_valid = v;
        bus_resp_data  = v ? rdata : scr;
        if (m_own_d) begin
          d_resp_ready = own_rdy; i_resp_ready = scr[5];
        end else begin
          i_resp_ready = own_rdy; d_resp_ready = scr[5];
        end
        @(negedge clk);
        chk("resp_bus_resp_ready", bus_resp_ready, own_rdy);
        chk("resp_owner_valid", m_own_d ? d_resp_valid : i_resp_valid, v);
        chk("resp_other_valid", m_own_d ? i_resp_valid : d_resp_valid, 1'b0);
        if (v) chk("resp_owner_data", m_own_d ? d_resp_data : i_resp_data, rdata);
        @(posedge clk); #1;
        m_stall++;
      end
      bus_resp_valid = 1'b0; i_resp_ready = 1'b1; d_resp_ready = 1'b1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    bit          won;
    logic [31:0] rnd, ra, rdd;
    int          rq, rs, rl;

    // Reset state
    do_reset();

    // Both request together out of reset: I first, then D
    grant(1'b1, 32'h0000_0200, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'h0, 1'b1, won);
    chk("conflict_first_is_i", won, 1'b0);
    i_req_valid = 1'b0;
    serve(1, 1, 0, 32'h1111_2222);
    grant(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'h0, 1'b0, won);
    chk("conflict_second_is_d", won, 1'b1);
    serve(0, 0, 0, 32'h3333_4444);
    chk("conflict_cnt_conflict", cnt_conflict, 32'd1);
    chk("conflict_cnt_i", cnt_i_grant, 32'd1);
    chk("conflict_cnt_d", cnt_d_grant, 32'd1);
    chk_cnt("conflict");

    // I only fetch, controller ready after 2 cycles
    do_reset();
    grant(1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, won);
    serve(2, 0, 0, 32'h0000_0013);
    chk("ifetch_cnt_i_grant", cnt_i_grant, 32'd1);
    chk_cnt("ifetch");

    // D write, then simultaneous rd+wr (treated as write), then I proves IDLE
    grant(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 4'b0011, 1'b0, won);
    serve(1, 0, 0, 32'h0);
    grant(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0024, 32'hCAFE_F00D, 4'b1100, 1'b0, won);
    serve(0, 0, 0, 32'h0);
    chk_cnt("dwrite");

    // D read with d_resp_ready low for 3 cycles
    grant(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0044, 32'h0, 4'h0, 1'b0, won);
    serve(0, 1, 3, 32'hA5A5_5A5A);
    chk_cnt("dread_bp");

    // Reset while waiting in RESP, then a late response must be drained
    grant(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0080, 32'h0, 4'h0, 1'b0, won);
    bus_req_ready = 1'b1;
    @(posedge clk); #1;
    bus_req_ready = 1'b0;
    d_resp_ready  = 1'b0;
    @(negedge clk);
    chk("mid_resp_bus_resp_ready", bus_resp_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_bus_resp_ready", bus_resp_ready, 1'b1);
    chk("async_rst_cnt_d_grant", cnt_d_grant, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    d_resp_ready = 1'b1;
    model_reset();
    bus_resp_valid = 1'b1;
    bus_resp_data  = 32'h0000_0055;
    @(negedge clk);
    chk("drain_resp_valid_pair", {i_resp_valid, d_resp_valid}, 2'b00);
    chk("drain_bus_resp_ready", bus_resp_ready, 1'b1);
    chk("drain_bus_req_valid", bus_req_valid, 1'b0);
    @(posedge clk); #1;
    bus_resp_valid = 1'b0;

    // Both requesting continuously: strict I,D alternation
    for (int k = 0; k < 8; k++) begin
      rnd = $urandom;
      grant(1'b1, 32'h0000_1000 + 32'(k * 4), 1'b0, 1'b1, 32'h0000_2000 + 32'(k * 4),
            rnd, 4'hF, 1'b1, won);
      chk("alternate_winner", won, (k % 2) == 1);
      serve(k % 3, 1, 0, ~rnd);
    end
    i_req_valid = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
    chk_cnt("alternate");

    // Randomized traffic against the model
    for (int it = 0; it < 40; it++) begin
      rnd = $urandom;
      ra  = $urandom;
      rdd = $urandom;
      if (rnd[2:0] == 3'b000) rnd[0] = 1'b1;
      rq = $urandom_range(0, 3);
      rs = $urandom_range(0, 2);
      rl = $urandom_range(0, 2);
      grant(rnd[0], ra, rnd[1], rnd[2], {rdd[31:2], 2'b00}, ~ra, rnd[7:4], 1'b0, won);
      serve(rq, rs, rl, rdd ^ ra);
    end
    chk_cnt("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
